// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings
// and the shift-counter width helper.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Counter must hold 0..WIDTH-1 and never collapse to zero bits.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/univ_shift_reg_cell.sv
// One bit of the universal shift register: 4:1 neighbour/load mux
// feeding an enabled flop with asynchronous active-high reset.
module shreg_cell
    import univ_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       ld_in,
    output logic       q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHL:  q_d = shl_in;
                MODE_SHR:  q_d = shr_in;
                MODE_LOAD: q_d = ld_in;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift left / shift right / load.
// Optional rotate taps on the end cells under UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si_l,
    input  logic             si_r,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             word_done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_w;
    logic             shl_src;
    logic             shr_src;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign shl_src = rot ? q_w[WIDTH-1] : si_l;
    assign shr_src = rot ? q_w[0] : si_r;
`else
    assign shl_src = si_l;
    assign shr_src = si_r;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shl_in;
        logic shr_in;

        if (i == 0) begin : g_lo
            assign shl_in = shl_src;
        end else begin : g_lo_n
            assign shl_in = q_w[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi
            assign shr_in = shr_src;
        end else begin : g_hi_n
            assign shr_in = q_w[i+1];
        end

        shreg_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .mode   (mode),
            .shl_in (shl_in),
            .shr_in (shr_in),
            .ld_in  (d[i]),
            .q      (q_w[i])
        );
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             word_done_q;
    logic             word_done_d;

    // Direction is irrelevant to the count; both shifts advance it.
    always_comb begin
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_SHL, MODE_SHR: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        word_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_LOAD: cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign q         = q_w;
    assign so_l      = q_w[WIDTH-1];
    assign so_r      = q_w[0];
    assign word_done = word_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): vector table,
// directed corner sequences and randomized run against a model.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         si_l = 1'b0;
    logic         si_r = 1'b0;
    logic         rot = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         so_l;
    logic         so_r;
    logic         word_done;

    int total = 0;
    int bad = 0;

    // model state: value as an integer, shifts since last load/reset
    int mq = 0;
    int nshift = 0;
    int mwd = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .si_l      (si_l),
        .si_r      (si_r),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot       (rot),
`endif
        .d         (d),
        .q         (q),
        .so_l      (so_l),
        .so_r      (so_r),
        .word_done (word_done)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".q"}, 64'(q), 64'(mq));
        check({name, ".so_l"}, 64'(so_l), 64'(mq / 128));
        check({name, ".so_r"}, 64'(so_r), 64'(mq % 2));
        check({name, ".wd"}, 64'(word_done), 64'(mwd));
    endtask

    task automatic model_edge();
        int rin;
        int lin;
        `ifdef UNIV_SHIFT_REG_ROTATE_EN
        lin = rot ? mq / 128 : int'(si_l);
        rin = rot ? mq % 2 : int'(si_r);
        `else
        lin = int'(si_l);
        rin = int'(si_r);
        `endif
        mwd = 0;
        if (en) begin
            if (mode == 2'b10) begin
                mq = (mq * 2) % 256 + lin;
                nshift++;
                mwd = (nshift % W == 0) ? 1 : 0;
            end else if (mode == 2'b01) begin
                mq = mq / 2 + 128 * rin;
                nshift++;
                mwd = (nshift % W == 0) ? 1 : 0;
            end else if (mode == 2'b11) begin
                mq = int'(d);
                nshift = 0;
            end
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m,
                        input logic sl, input logic sr,
                        input logic [W-1:0] dd, input logic rt,
                        input string name);
        en = e;
        mode = m;
        si_l = sl;
        si_r = sr;
        d = dd;
        rot = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_model(name);
    endtask

    // asserts reset mid-cycle, checks the async clear, releases after an edge
    task automatic do_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        check({name, ".async_q"}, 64'(q), 64'h0);
        check({name, ".async_wd"}, 64'(word_done), 64'h0);
        mq = 0;
        nshift = 0;
        mwd = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model({name, ".rel"});
    endtask

    typedef struct {
        logic         e;
        logic [1:0]   m;
        logic         sl;
        logic [W-1:0] exp_q;
        logic         exp_wd;
    } vec_t;

    vec_t vt[9];

    initial begin
        // SIPO left: si_l 1,0,1,1,0,0,1,0 -> B2 with one word_done
        vt[0] = '{1'b1, 2'b10, 1'b1, 8'h01, 1'b0};
        vt[1] = '{1'b1, 2'b10, 1'b0, 8'h02, 1'b0};
        vt[2] = '{1'b1, 2'b10, 1'b1, 8'h05, 1'b0};
        vt[3] = '{1'b1, 2'b10, 1'b1, 8'h0B, 1'b0};
        vt[4] = '{1'b1, 2'b10, 1'b0, 8'h16, 1'b0};
        vt[5] = '{1'b1, 2'b10, 1'b0, 8'h2C, 1'b0};
        vt[6] = '{1'b1, 2'b10, 1'b1, 8'h59, 1'b0};
        vt[7] = '{1'b1, 2'b10, 1'b0, 8'hB2, 1'b1};
        vt[8] = '{1'b1, 2'b00, 1'b1, 8'hB2, 1'b0};

        @(posedge clk);
        #1;
        check("reset.q", 64'(q), 64'h0);
        check("reset.wd", 64'(word_done), 64'h0);
        rst = 1'b0;

        // async reset with a pending load
        step(1, 2'b11, 0, 0, 8'hA5, 0, "preload");
        check("preload.q", 64'(q), 64'hA5);
        en = 1'b1;
        mode = 2'b11;
        d = 8'h5A;
        do_reset("rst_async");

        for (int i = 0; i < 9; i++) begin
            step(vt[i].e, vt[i].m, vt[i].sl, 1'b0, 8'h00, 1'b0, "sipo_m");
            check($sformatf("sipo[%0d].q", i), 64'(q), 64'(vt[i].exp_q));
            check($sformatf("sipo[%0d].wd", i), 64'(word_done),
                  64'(vt[i].exp_wd));
        end

        // PISO right from 81
        step(1, 2'b11, 0, 0, 8'h81, 0, "piso_ld");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("piso.so_r[%0d]", i), 64'(so_r),
                  (i == 0 || i == 7) ? 64'h1 : 64'h0);
            step(1, 2'b01, 0, 0, 8'h00, 0, "piso");
        end
        check("piso.q_end", 64'(q), 64'h0);
        check("piso.wd_end", 64'(word_done), 64'h1);
        step(1, 2'b00, 0, 0, 8'h00, 0, "piso_after");

        // enable gaps and hold do not count as shifts
        step(1, 2'b11, 0, 0, 8'h0F, 0, "gap_ld");
        for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 0, 0, 0, "gap_a");
        for (int i = 0; i < 4; i++) step(0, 2'b10, 1, 1, 0, 0, "gap_en0");
        for (int i = 0; i < 2; i++) step(1, 2'b00, 1, 1, 0, 0, "gap_hold");
        for (int i = 0; i < 4; i++) step(1, 2'b10, 0, 0, 0, 0, "gap_b");
        check("gap.wd_pre", 64'(word_done), 64'h0);
        step(1, 2'b10, 0, 0, 0, 0, "gap_8th");
        check("gap.q", 64'(q), 64'h00);
        check("gap.wd", 64'(word_done), 64'h1);
        step(0, 2'b10, 0, 0, 0, 0, "gap_en0_clr");
        check("gap.wd_clr", 64'(word_done), 64'h0);

        // load mid-word restarts the count
        for (int i = 0; i < 5; i++) step(1, 2'b01, 1, 1, 0, 0, "mid_a");
        step(1, 2'b11, 0, 0, 8'h3C, 0, "mid_ld");
        for (int i = 0; i < 7; i++) begin
            step(1, (i % 2) ? 2'b01 : 2'b10, 1, 0, 0, 0, "mid_b");
            check("mid.no_wd", 64'(word_done), 64'h0);
        end
        step(1, 2'b10, 1, 0, 0, 0, "mid_8th");
        check("mid.wd", 64'(word_done), 64'h1);
        // load right after wrap: pulse already set, then clears
        step(1, 2'b11, 0, 0, 8'h77, 0, "wrap_ld");
        check("wrap_ld.wd", 64'(word_done), 64'h0);

        // reset mid-word discards the count
        for (int i = 0; i < 5; i++) step(1, 2'b10, 1, 0, 0, 0, "rmid_a");
        do_reset("rst_mid");
        for (int i = 0; i < 7; i++) step(1, 2'b01, 1, 1, 0, 0, "rmid_b");
        check("rmid.no_wd", 64'(word_done), 64'h0);
        step(1, 2'b01, 1, 1, 0, 0, "rmid_8th");
        check("rmid.wd", 64'(word_done), 64'h1);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        step(1, 2'b11, 0, 0, 8'h81, 0, "rot_ld");
        step(1, 2'b10, 0, 1, 0, 1, "rot_l");
        check("rot.l", 64'(q), 64'h03);
        step(1, 2'b01, 1, 0, 0, 1, "rot_r1");
        step(1, 2'b01, 0, 1, 0, 1, "rot_r2");
        check("rot.r", 64'(q), 64'hC0);
`endif

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic rr;
            rr = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            rr = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 60) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step(1'($urandom_range(0, 5) != 0),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), rr, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
